// File: rtl/sad_pkg.sv
// sad_pkg: shared widths, FSM states and in-flight tag type for the SAD search controller
package sad_pkg;
  localparam int DWIDTH = 8;
  localparam int SAD_W = DWIDTH + 8;
  localparam int MV_W = 6;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  typedef struct packed {
    logic valid;
    logic signed [MV_W-1:0] mvx;
    logic signed [MV_W-1:0] mvy;
  } tag_t;
endpackage

// File: rtl/sad_tag_pipe.sv
// sad_tag_pipe: DEPTH-stage delay line of candidate tags that tracks the SAD datapath latency
module sad_tag_pipe import sad_pkg::*; #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic flush,
  input  tag_t d,
  output tag_t q
);
  tag_t sr [DEPTH];
  always_ff @(posedge clk) begin
    if (flush) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: full-search MV sequencer and running-minimum tracker around the SAD datapath.
// Define SAD_EARLY_TERM_EN to add threshold early termination (et_thresh / et_hit).
module sad_search_ctrl
  import sad_pkg::tag_t, sad_pkg::state_e, sad_pkg::IDLE, sad_pkg::ISSUE, sad_pkg::DRAIN, sad_pkg::DONE;
#(
  parameter int DWIDTH = 8,
  parameter int MV_W = 6,
  parameter int MAX_RANGE = 15,
  parameter int SAD_LAT = 6,
  parameter int SAD_W = DWIDTH + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MV_W-2:0]         srch_range,
  input  logic                    ref_rdy,
  output logic                    cal_en,
  output logic signed [MV_W-1:0]  cand_x,
  output logic signed [MV_W-1:0]  cand_y,
  input  logic [SAD_W-1:0]        sad,
  input  logic                    sad_vld,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  best_mvx,
  output logic signed [MV_W-1:0]  best_mvy,
  output logic                    tag_err
`ifdef SAD_EARLY_TERM_EN
  ,
  input  logic [SAD_W-1:0]        et_thresh,
  output logic                    et_hit
`endif
);
  localparam int CW = $clog2((2*MAX_RANGE+1)*(2*MAX_RANGE+1)+1);
  localparam logic [MV_W-2:0] RMAX = (MV_W-1)'(MAX_RANGE);
  state_e state;
  logic [MV_W-2:0] r, r_in;
  logic signed [MV_W-1:0] r_s, r_in_s;
  logic [CW-1:0] side, n_tot, icnt, rcnt, rcnt_nx;
  tag_t tag_d, tag_q;
  logic hit, et_now;
  assign r_in = srch_range > RMAX ? RMAX : srch_range;
  assign r_in_s = {1'b0, r_in};
  assign r_s = {1'b0, r};
  assign side = CW'({r, 1'b1});
  assign n_tot = side * side;
  assign hit = state != IDLE && sad_vld && tag_q.valid;
  assign rcnt_nx = rcnt + CW'(hit);
`ifdef SAD_EARLY_TERM_EN
  logic et_flag;
  assign et_now = state == ISSUE && hit && sad <= et_thresh;
`else
  assign et_now = 1'b0;
`endif
  // an early-termination hit suppresses the issue in its own cycle
  assign cal_en = state == ISSUE && ref_rdy && !et_now;
  assign tag_d = '{valid: cal_en, mvx: cand_x, mvy: cand_y};
  sad_tag_pipe #(.DEPTH(SAD_LAT)) u_tag (.clk(clk), .flush(rst), .d(tag_d), .q(tag_q));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      cand_x <= '0;
      cand_y <= '0;
      icnt <= '0;
      rcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      best_sad <= '0;
      best_mvx <= '0;
      best_mvy <= '0;
      tag_err <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
      et_flag <= 1'b0;
      et_hit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        rcnt <= rcnt_nx;
        if (sad_vld != tag_q.valid) tag_err <= 1'b1;
        // strict compare keeps the earliest raster candidate on ties
        if (hit && sad < best_sad) begin
          best_sad <= sad;
          best_mvx <= tag_q.mvx;
          best_mvy <= tag_q.mvy;
        end
      end
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          busy <= 1'b1;
          r <= r_in;
          cand_x <= -r_in_s;
          cand_y <= -r_in_s;
          icnt <= '0;
          rcnt <= '0;
          best_sad <= '1;
          tag_err <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
          et_flag <= 1'b0;
          et_hit <= 1'b0;
`endif
        end
        ISSUE: begin
          if (cal_en) begin
            icnt <= icnt + CW'(1);
            cand_x <= cand_x == r_s ? -r_s : cand_x + MV_W'(1);
            cand_y <= cand_x == r_s ? cand_y + MV_W'(1) : cand_y;
            if (icnt + CW'(1) == n_tot) state <= DRAIN;
          end
`ifdef SAD_EARLY_TERM_EN
          if (et_now) begin
            state <= DRAIN;
            et_flag <= 1'b1;
          end
`endif
        end
        DRAIN: if (rcnt_nx == icnt) begin
          state <= DONE;
          done <= 1'b1;
`ifdef SAD_EARLY_TERM_EN
          et_hit <= et_flag;
`endif
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
